mdu_sequencer: RTL and testbench

- Multi-cycle controller for the multiply/accumulate ops decoded by the ALU control path: MULT, MULTU, MADD, MADDU, MFHI and MFLO.
- Owns the architectural HI/LO registers and sequences a radix-2 shift-add multiplier over XLEN cycles.
- Sits beside the single-cycle ALU in EX; stalls the pipeline when MFHI/MFLO would read HI/LO mid-operation.
- Opcodes are the 6-bit alu_control codes: 011000 MULT, 011001 MULTU, 011100 MADD, 011101 MADDU, 010000 MFHI, 010010 MFLO.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_mul_step.sv | 21 ++
 rtl/mdu_sequencer.sv | 143 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit sequencer: opcodes, FSM states, default widths.
package mdu_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int OPC_W_DEFAULT = 6;

  localparam logic [5:0] OPC_MULT  = 6'b011000;
  localparam logic [5:0] OPC_MULTU = 6'b011001;
  localparam logic [5:0] OPC_MADD  = 6'b011100;
  localparam logic [5:0] OPC_MADDU = 6'b011101;
  localparam logic [5:0] OPC_MFHI  = 6'b010000;
  localparam logic [5:0] OPC_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_mul_step.sv
// One radix-2 shift-add iteration: add multiplicand into the upper half, then shift right by one.
module mdu_mul_step
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   mcand,
  input  logic [XLEN-1:0]   mplier,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0]   mplier_nxt
);

  logic [XLEN:0] sum;

  // The carry out of the upper half becomes the new MSB after the shift.
  assign sum        = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (mplier[0] ? mcand : '0)};
  assign acc_nxt    = {sum, acc[XLEN-1:1]};
  assign mplier_nxt = {1'b0, mplier[XLEN-1:1]};

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO owner and multi-cycle MULT/MULTU/MADD/MADDU sequencer with MFHI/MFLO read-out.
// Optional MDU_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int OPC_W = OPC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic [XLEN-1:0]  rs_val,
  input  logic [XLEN-1:0]  rt_val,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             stall,
  output logic [XLEN-1:0]  mf_result,
  output logic [XLEN-1:0]  hi,
  output logic [XLEN-1:0]  lo
);

  localparam int CW = $clog2(XLEN) + 1;

  mdu_state_t state_q, state_d;

  logic [2*XLEN-1:0] acc_q, step_acc, prod, wb;
  logic [XLEN-1:0]   mcand_q, mplier_q, step_mplier;
  logic [CW-1:0]     count_q;
  logic              neg_q, madd_q;
  logic              is_mul, is_signed, is_madd, is_mf, accept, last_bit, early;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

  assign is_signed = (opcode == OPC_MULT)  || (opcode == OPC_MADD);
  assign is_madd   = (opcode == OPC_MADD)  || (opcode == OPC_MADDU);
  assign is_mul    = is_signed || is_madd  || (opcode == OPC_MULTU);
  assign is_mf     = (opcode == OPC_MFHI)  || (opcode == OPC_MFLO);
  assign accept    = (state_q == IDLE) && start && !flush;
  assign last_bit  = (count_q == CW'(XLEN - 1));

`ifdef MDU_EARLY_TERM_EN
  assign early = (mplier_q == '0);
`else
  assign early = 1'b0;
`endif

  assign stall     = start && busy && is_mf;
  assign mf_result = (opcode == OPC_MFHI) ? hi : (opcode == OPC_MFLO) ? lo : '0;

  // Magnitude product is sign-corrected, then optionally accumulated onto {hi,lo}.
  assign prod = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign wb   = prod + (madd_q ? {hi, lo} : '0);

  mdu_mul_step #(.XLEN(XLEN)) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc_nxt    (step_acc),
    .mplier_nxt (step_mplier)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (accept && is_mul) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (flush)                  state_d = IDLE;
        else if (early || last_bit) state_d = FIN;
      end
      FIN: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      madd_q   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && is_mul) begin
            acc_q    <= '0;
            count_q  <= '0;
            mcand_q  <= is_signed ? mag(rs_val) : rs_val;
            mplier_q <= is_signed ? mag(rt_val) : rt_val;
            neg_q    <= is_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            madd_q   <= is_madd;
          end else if (accept && !is_mf) begin
            illegal <= 1'b1;
          end
        end
        RUN: begin
          if (!flush) begin
            // Early exit right-aligns the partial product by the steps skipped.
            if (early) acc_q <= acc_q >> (CW'(XLEN) - count_q);
            else       acc_q <= step_acc;
            mplier_q <= step_mplier;
            count_q  <= count_q + 1'b1;
          end
        end
        FIN: begin
          if (!flush) begin
            {hi, lo} <= wb;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases plus randomized traffic against a transaction-level model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        ready, busy, done, illegal, stall;
  logic [31:0] mf_result, hi, lo;

  int errors = 0;
  int checks = 0;

  mdu_sequencer #(.XLEN(XLEN), .OPC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .ready(ready), .busy(busy), .done(done), .illegal(illegal),
    .stall(stall), .mf_result(mf_result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_mul(input logic [5:0] op);
    return op == OPC_MULT || op == OPC_MULTU || op == OPC_MADD || op == OPC_MADDU;
  endfunction

  function automatic bit op_mf(input logic [5:0] op);
    return op == OPC_MFHI || op == OPC_MFLO;
  endfunction

  function automatic logic [63:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
    logic [63:0] p;
    if (op == OPC_MULT || op == OPC_MADD) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else                                  p = {32'b0, a} * {32'b0, b};
    if (op == OPC_MADD || op == OPC_MADDU) p = p + hilo;
    return p;
  endfunction

  // Transaction model: an accepted op completes XLEN+1 cycles later unless flushed.
  bit          m_pend = 1'b0, m_done = 1'b0, m_ill = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  int          cyc = 0, m_fin = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_done <= 1'b0; m_ill <= 1'b0;
      m_hi <= '0; m_lo <= '0; cyc <= 0;
    end else begin
      m_done <= 1'b0;
      m_ill  <= 1'b0;
      if (m_pend) begin
        if (flush) m_pend <= 1'b0;
        else if (cyc == m_fin) begin
          {m_hi, m_lo} <= m_res;
          m_done <= 1'b1;
          m_pend <= 1'b0;
        end
      end else if (start && !flush) begin
        if (op_mul(opcode)) begin
          m_pend <= 1'b1;
          m_res  <= ref_result(opcode, rs_val, rt_val, {m_hi, m_lo});
          m_fin  <= cyc + XLEN + 1;
        end else if (!op_mf(opcode)) begin
          m_ill <= 1'b1;
        end
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    #3;
    check("ready", ready, !m_pend);
    check("busy", busy, m_pend);
    check("done", done, m_done);
    check("illegal", illegal, m_ill);
    check("stall", stall, start && m_pend && op_mf(opcode));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("mf_result", mf_result,
          opcode == OPC_MFHI ? m_hi : (opcode == OPC_MFLO ? m_lo : 32'd0));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start = s; opcode = op; rs_val = a; rt_val = b;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, op, a, b);
    tick();
    drive(1'b0, 6'd0, '0, '0);
  endtask

  // Called one cycle after issue; n counts cycles since the issue cycle.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  initial begin
    int n, seen;
    logic [5:0] ops [8];
    ops = '{OPC_MULT, OPC_MULTU, OPC_MADD, OPC_MADDU, OPC_MFHI, OPC_MFLO, 6'b100000, 6'b011000};

    repeat (3) tick();
    check("rst_ready", ready, 1);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    issue(OPC_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(n);
    check("mult_latency", n, 34);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(OPC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    issue(OPC_MULT, 32'd5, 32'd6);
    wait_done(n);
    check("b2b_first", {hi, lo}, 64'd30);
    issue(OPC_MADD, 32'd2, 32'd3);
    wait_done(n);
    check("b2b_latency", n, 34);
    check("b2b_madd", {hi, lo}, 64'h24);

    issue(OPC_MULTU, 32'h8000_0000, 32'd4);
    repeat (9) tick();
    drive(1'b1, OPC_MFHI, '0, '0);
    n = 0;
    while (!done && n < 100) begin
      #1;
      check("stall_hold", stall, 1);
      tick();
      n++;
    end
    #1;
    check("stall_clear", stall, 0);
    check("mfhi_new", mf_result, 32'd2);
    drive(1'b0, 6'd0, '0, '0);

    issue(OPC_MULTU, 32'd2, 32'h8000_0001);
    wait_done(n);
    check("preload", {hi, lo}, 64'h1_0000_0002);
    issue(OPC_MULT, 32'd9, 32'd9);
    repeat (19) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", ready, 1);
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen++;
    end
    check("flush_nodone", seen, 0);
    check("flush_hilo", {hi, lo}, 64'h1_0000_0002);

    drive(1'b1, 6'b100000, 32'd1, 32'd1);
    tick();
    drive(1'b0, 6'd0, '0, '0);
    check("illegal_pulse", illegal, 1);
    check("illegal_idle", ready, 1);
    tick();
    check("illegal_once", illegal, 0);

    issue(OPC_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
    issue(OPC_MULT, 32'h8000_0000, 32'd1);
    wait_done(n);
    check("mult_min1", {hi, lo}, 64'hFFFF_FFFF_8000_0000);

    repeat (1500) begin
      tick();
      start = ($urandom_range(0, 1) == 1);
      opcode = ops[$urandom_range(0, 7)];
      flush = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 5))
        0:       rs_val = 32'h8000_0000;
        1:       rs_val = 32'hFFFF_FFFF;
        2:       rs_val = 32'd0;
        default: rs_val = $urandom;
      endcase
      rt_val = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
    end
    drive(1'b0, 6'd0, '0, '0);
    flush = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check("drain_ready", ready, 1);

    issue(OPC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    issue(OPC_MULT, 32'd3, 32'd3);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_ready", ready, 1);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
